// File: rtl/core_run_controller.sv
// Run/halt/single-step sequencer: gates instruction commit, PC breakpoint, error halt, retire counter.
// Latency: commitEnable is combinational; halted/haltCause/retiredCount update on the closing edge.
// Backpressure: none; the core simply does not commit while commitEnable is low.
module core_run_controller #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter bit          START_HALTED      = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        haltRequest,
    input  logic        resumeRequest,
    input  logic        stepRequest,
    input  logic        breakpointEnable,
    input  logic [31:0] breakpointAddress,
    input  logic [31:0] pcOfInstruction,
    input  logic        programCounterMisaligned,
    input  logic        memoryUnalignedAccess,
    input  logic        memoryBadFunct3,
    output logic        commitEnable,
    output logic        halted,
    output logic [2:0]  haltCause,
    output logic [63:0] retiredCount
);

    typedef enum logic [1:0] {HOLD, RUN, HALTED, STEP} state_t;

    localparam logic [2:0] CAUSE_NONE       = 3'd0;
    localparam logic [2:0] CAUSE_HALT_REQ   = 3'd1;
    localparam logic [2:0] CAUSE_BREAKPOINT = 3'd2;
    localparam logic [2:0] CAUSE_STEP       = 3'd3;
    localparam logic [2:0] CAUSE_ERROR      = 3'd4;

    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    state_t     state;
    logic [7:0] holdCount;
    logic       skipBp;
    logic       resumePrev;
    logic       stepPrev;

    logic err;
    logic bpHit;
    logic resumeEdge;
    logic stepEdge;

    always_comb begin
        err          = programCounterMisaligned | memoryUnalignedAccess | memoryBadFunct3;
        bpHit        = breakpointEnable && (pcOfInstruction == breakpointAddress) && !skipBp;
        resumeEdge   = resumeRequest & ~resumePrev;
        stepEdge     = stepRequest & ~stepPrev;
        commitEnable = ((state == RUN) || (state == STEP)) && !err && !(bpHit && (state == RUN));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= HOLD;
            holdCount    <= 8'd0;
            skipBp       <= 1'b0;
            resumePrev   <= 1'b0;
            stepPrev     <= 1'b0;
            halted       <= 1'b0;
            haltCause    <= CAUSE_NONE;
            retiredCount <= 64'd0;
        end else begin
            resumePrev <= resumeRequest;
            stepPrev   <= stepRequest;
            // skipBp only survives the single RUN cycle that follows a resume
            skipBp     <= 1'b0;
            if (commitEnable) begin
                retiredCount <= retiredCount + 64'd1;
            end
            case (state)
                HOLD: begin
                    if (holdCount == HOLD_LAST) begin
                        if (START_HALTED) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                        haltCause <= CAUSE_NONE;
                    end else begin
                        holdCount <= holdCount + 8'd1;
                    end
                end
                RUN: begin
                    if (err) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        haltCause <= CAUSE_ERROR;
                    end else if (bpHit) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        haltCause <= CAUSE_BREAKPOINT;
                    end else if (haltRequest) begin
                        state     <= HALTED;
                        halted    <= 1'b1;
                        haltCause <= CAUSE_HALT_REQ;
                    end
                end
                HALTED: begin
                    if (resumeEdge) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        skipBp <= 1'b1;
                    end else if (stepEdge) begin
                        state  <= STEP;
                        halted <= 1'b0;
                    end
                end
                STEP: begin
                    state     <= HALTED;
                    halted    <= 1'b1;
                    haltCause <= err ? CAUSE_ERROR : CAUSE_STEP;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed test-plan scenarios then random stimulus,
// every cycle compared against a behavioural model of the run/halt rules.
module tb_core_run_controller;

    localparam int HOLD_CYCLES = 4;

    localparam int M_HOLD   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_STEP   = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        haltRequest = 1'b0;
    logic        resumeRequest = 1'b0;
    logic        stepRequest = 1'b0;
    logic        breakpointEnable = 1'b0;
    logic [31:0] breakpointAddress = 32'h0;
    logic [31:0] pcOfInstruction = 32'h0;
    logic        programCounterMisaligned = 1'b0;
    logic        memoryUnalignedAccess = 1'b0;
    logic        memoryBadFunct3 = 1'b0;
    logic        commitEnable;
    logic        halted;
    logic [2:0]  haltCause;
    logic [63:0] retiredCount;

    int vectorCount = 0;
    int missCount   = 0;

    int          mMode;
    int          mHoldSeen;
    bit          mSkip;
    bit          mPrevRes;
    bit          mPrevStep;
    bit          mHalted;
    logic [2:0]  mCause;
    logic [63:0] mCount;

    core_run_controller #(
        .RESET_HOLD_CYCLES(HOLD_CYCLES),
        .START_HALTED(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .haltRequest(haltRequest),
        .resumeRequest(resumeRequest),
        .stepRequest(stepRequest),
        .breakpointEnable(breakpointEnable),
        .breakpointAddress(breakpointAddress),
        .pcOfInstruction(pcOfInstruction),
        .programCounterMisaligned(programCounterMisaligned),
        .memoryUnalignedAccess(memoryUnalignedAccess),
        .memoryBadFunct3(memoryBadFunct3),
        .commitEnable(commitEnable),
        .halted(halted),
        .haltCause(haltCause),
        .retiredCount(retiredCount)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectorCount++;
        if (got !== want) begin
            missCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void modelReset();
        mMode     = M_HOLD;
        mHoldSeen = 0;
        mSkip     = 1'b0;
        mPrevRes  = 1'b0;
        mPrevStep = 1'b0;
        mHalted   = 1'b0;
        mCause    = 3'd0;
        mCount    = 64'd0;
    endfunction

    function automatic bit modelErr();
        return programCounterMisaligned || memoryUnalignedAccess || memoryBadFunct3;
    endfunction

    function automatic bit modelCommit();
        bit atBreak;
        atBreak = breakpointEnable && (pcOfInstruction == breakpointAddress) && !mSkip;
        if (modelErr()) return 1'b0;
        if (mMode == M_STEP) return 1'b1;
        return (mMode == M_RUN) && !atBreak;
    endfunction

    function automatic void haltWith(input logic [2:0] cause);
        mMode   = M_HALTED;
        mHalted = 1'b1;
        mCause  = cause;
    endfunction

    function automatic void modelAdvance(input bit committed);
        bit atBreak;
        bit resRise;
        bit stepRise;
        atBreak  = breakpointEnable && (pcOfInstruction == breakpointAddress) && !mSkip;
        resRise  = resumeRequest && !mPrevRes;
        stepRise = stepRequest && !mPrevStep;
        mPrevRes  = resumeRequest;
        mPrevStep = stepRequest;
        mSkip     = 1'b0;
        if (committed) mCount = mCount + 64'd1;
        case (mMode)
            M_HOLD: begin
                mHoldSeen++;
                if (mHoldSeen == HOLD_CYCLES) mMode = M_RUN;
            end
            M_RUN: begin
                if (modelErr()) haltWith(3'd4);
                else if (atBreak) haltWith(3'd2);
                else if (haltRequest) haltWith(3'd1);
            end
            M_HALTED: begin
                if (resRise) begin
                    mMode = M_RUN; mHalted = 1'b0; mSkip = 1'b1;
                end else if (stepRise) begin
                    mMode = M_STEP; mHalted = 1'b0;
                end
            end
            default: haltWith(modelErr() ? 3'd4 : 3'd3);
        endcase
    endfunction

    // One core cycle: inputs are already stable from posedge+1; check mid-cycle, advance on the edge.
    task automatic tick();
        bit expCommit;
        @(negedge clock);
        #1;
        expCommit = modelCommit();
        checkValue("commitEnable", 64'(commitEnable), 64'(expCommit));
        checkValue("halted", 64'(halted), 64'(mHalted));
        checkValue("haltCause", 64'(haltCause), 64'(mCause));
        checkValue("retiredCount", retiredCount, mCount);
        @(posedge clock);
        modelAdvance(expCommit);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkValue("rst_commit", 64'(commitEnable), 64'd0);
        checkValue("rst_halted", 64'(halted), 64'd0);
        checkValue("rst_cause", 64'(haltCause), 64'd0);
        checkValue("rst_count", retiredCount, 64'd0);
        reset = 1'b0;

        // Reset hold: 4 blocked cycles, then 10 commits
        repeat (HOLD_CYCLES + 10) tick();
        checkValue("hold_count10", retiredCount, 64'd10);

        // Breakpoint at 0x10 with PC 0,4,8,0x10
        breakpointEnable  = 1'b1;
        breakpointAddress = 32'h10;
        pcOfInstruction = 32'h0;  tick();
        pcOfInstruction = 32'h4;  tick();
        pcOfInstruction = 32'h8;  tick();
        pcOfInstruction = 32'h10; tick();
        checkValue("bp_count", retiredCount, 64'd13);
        checkValue("bp_halted", 64'(halted), 64'd1);
        checkValue("bp_cause", 64'(haltCause), 64'd2);
        resumeRequest = 1'b1; tick();
        resumeRequest = 1'b0; tick();
        checkValue("bp_resume_count", retiredCount, 64'd14);
        pcOfInstruction = 32'h14; tick();
        checkValue("bp_run_on", 64'(halted), 64'd0);

        // Halt request commits the current instruction
        haltRequest = 1'b1; pcOfInstruction = 32'h18; tick();
        haltRequest = 1'b0;
        checkValue("hreq_cause", 64'(haltCause), 64'd1);
        checkValue("hreq_count", retiredCount, 64'd16);

        // Three one-cycle step pulses, then a step held for 5 cycles
        for (int i = 0; i < 3; i++) begin
            stepRequest = 1'b1; tick();
            stepRequest = 1'b0; tick(); tick();
            checkValue("step_halted", 64'(halted), 64'd1);
            checkValue("step_cause", 64'(haltCause), 64'd3);
        end
        checkValue("step_count", retiredCount, 64'd19);
        stepRequest = 1'b1; repeat (5) tick();
        stepRequest = 1'b0; tick();
        checkValue("step_held_count", retiredCount, 64'd20);

        // Error together with a breakpoint match: error wins, nothing commits
        resumeRequest = 1'b1; tick();
        resumeRequest = 1'b0;
        pcOfInstruction = 32'h20; tick();
        pcOfInstruction = 32'h24; tick();
        pcOfInstruction = 32'h10; memoryUnalignedAccess = 1'b1;
        #1;
        checkValue("err_commit", 64'(commitEnable), 64'd0);
        tick();
        memoryUnalignedAccess = 1'b0;
        checkValue("err_cause", 64'(haltCause), 64'd4);
        checkValue("err_count", retiredCount, 64'd22);

        // Simultaneous resume and step edges: resume wins
        resumeRequest = 1'b1; stepRequest = 1'b1; tick();
        resumeRequest = 1'b0; stepRequest = 1'b0;
        pcOfInstruction = 32'h30; tick();
        pcOfInstruction = 32'h34; tick();
        checkValue("res_step_run", 64'(halted), 64'd0);
        haltRequest = 1'b1; tick();
        haltRequest = 1'b0;

        // Reset asserted while in STEP
        stepRequest = 1'b1; tick();
        stepRequest = 1'b0;
        #1;
        checkValue("step_before_rst", 64'(commitEnable), 64'd1);
        reset = 1'b1;
        #1;
        checkValue("midrst_commit", 64'(commitEnable), 64'd0);
        checkValue("midrst_halted", 64'(halted), 64'd0);
        checkValue("midrst_cause", 64'(haltCause), 64'd0);
        checkValue("midrst_count", retiredCount, 64'd0);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (HOLD_CYCLES + 2) tick();

        // Counter wrap from all-ones
        pcOfInstruction = 32'h40;
        dut.retiredCount = '1;
        mCount = '1;
        tick();
        checkValue("wrap_count", retiredCount, 64'd0);

        // Random stimulus against the model
        breakpointAddress = 32'h44;
        for (int i = 0; i < 1500; i++) begin
            haltRequest      = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) resumeRequest = ~resumeRequest;
            if ($urandom_range(0, 3) == 0) stepRequest = ~stepRequest;
            breakpointEnable = ($urandom_range(0, 3) != 0);
            pcOfInstruction  = ($urandom_range(0, 2) == 0) ? breakpointAddress : ($urandom() & 32'hFC);
            programCounterMisaligned = ($urandom_range(0, 39) == 0);
            memoryUnalignedAccess    = ($urandom_range(0, 39) == 0);
            memoryBadFunct3          = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/core_run_controller.md
# core_run_controller

Run/halt/single-step sequencer for the single-cycle core. Every cycle the core would retire an instruction, this block decides whether it may commit. Its `commitEnable` output gates the program counter write, register-file write and memory write enables at the core top. It adds a hardware breakpoint on the PC, halts on datapath error flags, supports debugger halt, resume and step requests, and counts retired instructions.

## Interface
- `RESET_HOLD_CYCLES`, default 4: cycles after reset with commits blocked; range 1–255.
- `START_HALTED`, default 0: 1 means the block leaves HOLD into HALTED instead of RUN.
- `clock`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `haltRequest`  in  1  level; debugger halt request.
- `resumeRequest`  in  1  rising-edge sensitive; leave HALTED into RUN.
- `stepRequest`  in  1  rising-edge sensitive; commit exactly one instruction from HALTED.
- `breakpointEnable`  in  1  enables the PC compare.
- `breakpointAddress`  in  32  PC to stop at.
- `pcOfInstruction`  in  32  PC of the instruction executing this cycle.
- `programCounterMisaligned`, `memoryUnalignedAccess`, `memoryBadFunct3`  in  1 each  datapath error flags.
- `commitEnable`  out  1  combinational; the current instruction may commit.
- `halted`  out  1  registered; state is HALTED.
- `haltCause`  out  3  registered; 0 NONE, 1 HALT_REQ, 2 BREAKPOINT, 3 STEP, 4 ERROR.
- `retiredCount`  out  64  registered; instructions committed.

## Operation
- States: HOLD, RUN, HALTED, STEP. On reset the state is HOLD and the hold counter is 0.
- Internal signals:
  - `err` = OR of the three error flags.
  - `bpHit` = `breakpointEnable` and `pcOfInstruction == breakpointAddress` and not `skipBp`.
- `commitEnable` = (state is RUN or STEP) and not `err` and not (`bpHit` and state is RUN).
- `retiredCount` increments by 1 on every edge where `commitEnable` = 1. It wraps 2^64−1 → 0 with no flag.
- Rising edges of `resumeRequest` and `stepRequest` are detected against their values registered the previous cycle. Both previous-value registers reset to 0, so an input held high through reset produces no edge.
- HOLD:
  - Counts cycles; after `RESET_HOLD_CYCLES` cycles, goes to RUN (or to HALTED with cause NONE if `START_HALTED`).
  - All requests are ignored in HOLD.
- RUN, with transition priority error > breakpoint > haltRequest:
  - `err`: go to HALTED, cause ERROR; no commit this cycle.
  - `bpHit`: go to HALTED, cause BREAKPOINT; the instruction at the breakpoint has not committed.
  - `haltRequest`: the current instruction commits, then go to HALTED, cause HALT_REQ.
  - Otherwise stay in RUN.
- HALTED:
  - A resume edge goes to RUN. Resume takes priority over a simultaneous step edge.
  - A step edge goes to STEP.
  - `haltRequest` has no effect while HALTED. `haltCause` holds its value.
- STEP (always exactly one cycle):
  - Breakpoint compare is ignored.
  - If `err`, go to HALTED with cause ERROR and no commit.
  - Otherwise commit and go to HALTED with cause STEP.
- `skipBp`:
  - Set on the HALTED→RUN transition and cleared after the first RUN cycle. This lets a resume from a breakpoint execute that instruction once.
  - `skipBp` = 0 in every other state.
- RUN with resume and halt both active:
  - If `haltRequest` is still high on the first RUN cycle, that one instruction commits and the block re-halts with cause HALT_REQ.
  - Holding `haltRequest` high therefore makes each resume behave like a step.
- ERROR halts persist until resume or step. If the error flag is still asserted, the block halts again immediately with no commit.
- Reset mid-operation: everything returns to its reset value asynchronously, and any pending commit is lost (`commitEnable` drops immediately).

## Timing
- Reset values: state HOLD, `commitEnable` 0, `halted` 0, `haltCause` 0, `retiredCount` 0, hold counter 0, `skipBp` 0, edge registers 0.
- `commitEnable` has zero latency from `pcOfInstruction` and the error flags; the breakpoint compare is in the same cycle.
- `halted` and `haltCause` update on the edge that ends the halting cycle, so they are visible one cycle after the cause.
- Resume or step edge at cycle n: `halted` = 0 and `commitEnable` = 1 in cycle n+1. For a step, `halted` = 1 again in cycle n+2.
- After `reset` deasserts, the first cycle with `commitEnable` = 1 is cycle `RESET_HOLD_CYCLES` + 1.

## Test plan
- **Reset hold:** reset, release, no requests, `RESET_HOLD_CYCLES` = 4 → `commitEnable` = 0 for 4 cycles, then 1; after 10 further cycles `retiredCount` = 10.
- **Breakpoint and resume:**
  - Breakpoint at 0x00000010, PC sequence 0,4,8,0x10 → halt with `haltCause` = 2, `retiredCount` = 3, no commit at 0x10.
  - Resume pulse → 0x10 commits, `retiredCount` = 4, RUN continues.
- **Single step:** halted, three separate step pulses each 1 cycle wide → exactly 3 increments, `haltCause` = 3, `halted` = 1 after each; a step held high for 5 cycles → only 1 commit.
- **Error halt:** in RUN, assert `memoryUnalignedAccess` for one cycle together with a breakpoint match → `commitEnable` = 0, `haltCause` = 4, no count change.
- **Halt request and priority:**
  - `haltRequest` high for one cycle in RUN → that instruction commits, `haltCause` = 1.
  - Simultaneous resume and step edges while halted → RUN (`halted` = 0 for more than 1 cycle).
- **Reset mid-operation and wrap:**
  - Assert `reset` during STEP → `commitEnable` falls immediately, all outputs 0, state HOLD.
  - Force `retiredCount` to 2^64−1 and commit → count 0.
